drum_prod_acc: RTL and testbench

- Streaming accumulator directly downstream of the 16x16 DRUM approximate multiplier.
- Takes the 32-bit unsigned approximate products one beat at a time over a valid/ready handshake and sums them into a wide unsigned accumulator. The sum saturates instead of wrapping.
- A frame ends on the beat flagged last. The frame sum, beat count and saturation flag are then presented on a registered output handshake.
- Typical use: dot-product / filter-tap reduction behind the DRUM multiplier.

---
 rtl/drum_prod_acc_if.sv | 43 ++++
 rtl/drum_prod_acc.sv | 166 ++++++++++++++++
 tb/tb_drum_prod_acc.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/drum_prod_acc_if.sv
// -----------------------------------------------------------------------------
// drum_prod_acc_if
//   Stream bundle between the DRUM multiplier, the product accumulator and the
//   consumer of frame results.
//
//   Signals
//     in_valid  / in_ready   : product beat handshake
//     in_prod   [PW-1:0]     : unsigned approximate product
//     in_last                : beat closes the current frame
//     out_valid / out_ready  : frame result handshake
//     out_sum   [AW-1:0]     : saturated frame sum
//     out_cnt   [CW-1:0]     : beats in frame, saturating
//     out_sat                : sum saturated during the frame
//
//   Modports
//     master : the environment (drives beats, accepts results)
//     slave  : the accumulator
// -----------------------------------------------------------------------------
interface drum_prod_acc_if #(
   parameter int PW = 32,
   parameter int AW = 40,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_prod;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_cnt;
   logic          out_sat;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_cnt, out_sat
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_cnt, out_sat
   );
endinterface

// File: rtl/drum_prod_acc.sv
// -----------------------------------------------------------------------------
// drum_prod_acc
//   Streaming, saturating accumulator placed behind the 16x16 DRUM approximate
//   multiplier. Unsigned products arrive one beat at a time; the beat flagged
//   in_last closes a frame, whose sum, beat count and saturation flag are then
//   offered on a registered result handshake.
//
//   Parameters
//     PW : product width (multiplier output width)
//     AW : accumulator / result width, AW >= PW
//     CW : beat counter width; the count saturates at 2^CW-1
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : drum_prod_acc_if.slave (beat input + result output)
//
//   Behaviour summary
//     ACC  : in_ready=1, out_valid=0, beats accumulate.
//     HOLD : out_valid=1, in_ready follows out_ready so a new frame can start
//            in the same cycle the pending result is consumed. A single-beat
//            frame arriving then reloads the result and stays in HOLD.
// -----------------------------------------------------------------------------
module drum_prod_acc #(
   parameter int PW = 32,
   parameter int AW = 40,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   drum_prod_acc_if.slave  bus
);

   // Reject configurations where the accumulator cannot hold one product.
   if (AW < PW) begin : g_aw_check
      $error("drum_prod_acc: AW must be >= PW");
   end

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [AW-1:0] ACC_MAX = '1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t        state;
   state_t        state_nxt;

   // Running frame state
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          sat;

   // Result registers, held after transfer until the next frame closes
   logic [AW-1:0] sum_q;
   logic [CW-1:0] cnt_q;
   logic          sat_q;

   // Beat arithmetic
   logic [AW:0]   sum_wide;
   logic          ovf;
   logic [AW-1:0] sum_nxt;
   logic [CW-1:0] cnt_nxt;

   logic          in_ready;
   logic          out_valid;
   logic          beat;

   // Ready is forced low while reset is asserted; in HOLD it passes out_ready
   // through so the result slot is freed and refilled in one cycle.
   assign in_ready = rst_n && ((state == ST_ACC) || bus.out_ready);
   assign beat     = bus.in_valid && in_ready;

   // ---------------------------------------------------------------------------
   // Beat arithmetic: one extra bit catches the carry out of the AW-bit sum.
   // An accumulator already pinned at all-ones also counts as overflow so the
   // flag is raised for every beat that lands on a saturated sum.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves a signal unassigned and infers a latch.
      sum_wide = {1'b0, acc} + (AW+1)'(bus.in_prod);
      ovf      = sum_wide[AW] || (acc == ACC_MAX);
      sum_nxt  = ovf ? ACC_MAX : sum_wide[AW-1:0];
      cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         state <= ST_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      unique case (state)
         ST_ACC: begin
            if (beat && bus.in_last) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            // A closing beat accepted alongside the transfer reloads the
            // result, so the block stays in HOLD for a back-to-back result.
            if (beat && bus.in_last) begin
               state_nxt = ST_HOLD;
            end else if (bus.out_ready) begin
               state_nxt = ST_ACC;
            end
         end
         default: begin
            state_nxt = ST_ACC;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Accumulator and result registers. acc is zero on entry to HOLD, so a beat
   // accepted in HOLD naturally starts the new frame from zero.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: result registers are reset too: out_sum/out_cnt/out_sat must read
      // zero after reset, not only be qualified by out_valid.
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         sat   <= 1'b0;
         sum_q <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else if (beat) begin
         if (bus.in_last) begin
            sum_q <= sum_nxt;
            cnt_q <= cnt_nxt;
            sat_q <= sat | ovf;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
         end else begin
            acc   <= sum_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat | ovf;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = sum_q;
   assign bus.out_cnt   = cnt_q;
   assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_drum_prod_acc.sv
// -----------------------------------------------------------------------------
// tb_drum_prod_acc
//   Directed bench for drum_prod_acc. Three instances share one stimulus:
//     u_dut_a : default widths (PW=32, AW=40, CW=8)
//     u_dut_s : AW=33, to reach sum saturation with 32-bit products
//     u_dut_c : CW=2, to reach count saturation with a few beats
//   Handshake state depends only on the shared inputs, so u_dut_a's in_ready
//   paces all three. Inputs change on the falling edge, outputs are sampled on
//   the falling edge (or 1 time unit after it).
// -----------------------------------------------------------------------------
module tb_drum_prod_acc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_prod;
   logic        in_last;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int n_xfer   = 0;

   drum_prod_acc_if #(.PW(32), .AW(40), .CW(8)) bus_a ();
   drum_prod_acc_if #(.PW(32), .AW(33), .CW(8)) bus_s ();
   drum_prod_acc_if #(.PW(32), .AW(40), .CW(2)) bus_c ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_prod   = in_prod;
   assign bus_a.in_last   = in_last;
   assign bus_a.out_ready = out_ready;
   assign bus_s.in_valid  = in_valid;
   assign bus_s.in_prod   = in_prod;
   assign bus_s.in_last   = in_last;
   assign bus_s.out_ready = out_ready;
   assign bus_c.in_valid  = in_valid;
   assign bus_c.in_prod   = in_prod;
   assign bus_c.in_last   = in_last;
   assign bus_c.out_ready = out_ready;

   drum_prod_acc #(.PW(32), .AW(40), .CW(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   drum_prod_acc #(.PW(32), .AW(33), .CW(8)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
   drum_prod_acc #(.PW(32), .AW(40), .CW(2)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count result transfers on the default instance.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1)
         n_xfer++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one beat from a falling edge, hold it until accepted, then drop it.
   task automatic send(input logic [31:0] p, input logic l);
      bit ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus_a.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("send_ready_timeout", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
      check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("rst_out_sum",   64'(bus_a.out_sum),   64'd0);
      check("rst_out_cnt",   64'(bus_a.out_cnt),   64'd0);
      check("rst_out_sat",   64'(bus_a.out_sat),   64'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready",  64'(bus_a.in_ready),  64'd1);

      // ---------------- basic frame ----------------
      send(32'd100, 1'b0);
      @(negedge clk);
      check("basic_mid_valid", 64'(bus_a.out_valid), 64'd0);
      send(32'd200, 1'b0);
      send(32'd300, 1'b1);
      @(negedge clk);
      check("basic_valid", 64'(bus_a.out_valid), 64'd1);
      check("basic_sum",   64'(bus_a.out_sum),   64'd600);
      check("basic_cnt",   64'(bus_a.out_cnt),   64'd3);
      check("basic_sat",   64'(bus_a.out_sat),   64'd0);
      @(negedge clk);
      check("basic_drop",  64'(bus_a.out_valid), 64'd0);

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      send(32'd300, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid",    64'(bus_a.out_valid), 64'd1);
         check("bp_sum",      64'(bus_a.out_sum),   64'd600);
         check("bp_cnt",      64'(bus_a.out_cnt),   64'd3);
         check("bp_in_ready", 64'(bus_a.in_ready),  64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_pass_ready", 64'(bus_a.in_ready), 64'd1);
      @(negedge clk);
      check("bp_after_valid", 64'(bus_a.out_valid), 64'd0);
      check("bp_after_ready", 64'(bus_a.in_ready),  64'd1);
      check("bp_after_hold",  64'(bus_a.out_sum),   64'd600);

      // ---------------- sum saturation ----------------
      send(32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      check("sat_sum_33",  64'(bus_s.out_sum), 64'h1_FFFF_FFFF);
      check("sat_flag_33", 64'(bus_s.out_sat), 64'd1);
      check("sat_cnt_33",  64'(bus_s.out_cnt), 64'd3);
      check("sat_sum_40",  64'(bus_a.out_sum), 64'h2_FFFF_FFFD);
      check("sat_flag_40", 64'(bus_a.out_sat), 64'd0);
      send(32'd5, 1'b1);
      @(negedge clk);
      check("sat_next_sum",  64'(bus_s.out_sum), 64'd5);
      check("sat_next_flag", 64'(bus_s.out_sat), 64'd0);
      check("sat_next_cnt",  64'(bus_s.out_cnt), 64'd1);

      // ---------------- back-to-back single-beat frames ----------------
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_prod  = 32'd7;
      @(posedge clk);
      #1 in_prod = 32'd9;
      @(negedge clk);
      check("b2b_valid_0", 64'(bus_a.out_valid), 64'd1);
      check("b2b_sum_0",   64'(bus_a.out_sum),   64'd7);
      check("b2b_cnt_0",   64'(bus_a.out_cnt),   64'd1);
      check("b2b_ready_0", 64'(bus_a.in_ready),  64'd1);
      @(posedge clk);
      #1 in_prod = 32'd11;
      @(negedge clk);
      check("b2b_valid_1", 64'(bus_a.out_valid), 64'd1);
      check("b2b_sum_1",   64'(bus_a.out_sum),   64'd9);
      check("b2b_cnt_1",   64'(bus_a.out_cnt),   64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("b2b_valid_2", 64'(bus_a.out_valid), 64'd1);
      check("b2b_sum_2",   64'(bus_a.out_sum),   64'd11);
      check("b2b_cnt_2",   64'(bus_a.out_cnt),   64'd1);
      @(negedge clk);
      check("b2b_drop",    64'(bus_a.out_valid), 64'd0);

      // ---------------- count saturation ----------------
      for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
      send(32'd1, 1'b1);
      @(negedge clk);
      check("cnt_sat_sum_c", 64'(bus_c.out_sum), 64'd5);
      check("cnt_sat_cnt_c", 64'(bus_c.out_cnt), 64'd3);
      check("cnt_sat_cnt_a", 64'(bus_a.out_cnt), 64'd5);

      // ---------------- reset mid-frame ----------------
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 64'(bus_a.in_ready),  64'd0);
      check("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_sum",    64'(bus_a.out_sum),   64'd0);
      check("mid_rst_valid2", 64'(bus_a.out_valid), 64'd0);
      send(32'd4, 1'b1);
      @(negedge clk);
      check("mid_rst_new_sum", 64'(bus_a.out_sum),   64'd4);
      check("mid_rst_new_cnt", 64'(bus_a.out_cnt),   64'd1);
      check("mid_rst_new_vld", 64'(bus_a.out_valid), 64'd1);
      @(negedge clk);

      // One transfer per closed frame: 1 + 1 + 2 + 3 + 1 + 1.
      check("xfer_count", 64'(n_xfer), 64'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
